mips_bus_stall_memory: RTL and testbench
========================================

# mips_bus_stall_memory

Parametrised Avalon-style word-addressed memory slave for the `mips_cpu_bus` test environment, replacing the fixed-latency `request_memory` model. It adds:

- a configurable base address;
- separate read and write wait-state counts;
- an optional pseudo-random stall mode;
- sticky protocol and out-of-range error flags.

It sits between the CPU bus master and the testbench so the CPU can be exercised against arbitrary `waitrequest` patterns.

## Interface
- `DEPTH_WORDS`, 1024, number of 32-bit words stored.
- `INIT_FILE`, "", hex file loaded with `$readmemh` at time 0; empty string means no load (contents X).
- `BASE_ADDR`, 32'hBFC00000, byte address of word 0.
- `READ_WAIT`, 1, wait states per read in fixed mode (0..15).
- `WRITE_WAIT`, 1, wait states per write in fixed mode (0..15).
- `STALL_MODE`, 0, 0 = fixed wait counts; 1 = pseudo-random 0..3 wait states.
- `LFSR_SEED`, 16'hACE1, initial LFSR value; 0 is replaced by 16'hACE1.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `address`  input  32  byte address; bits [1:0] ignored.
- `read`  input  1  read request.
- `write`  input  1  write request.
- `byteenable`  input  4  byte lane enables for writes; bit n enables writedata[8n+7:8n].
- `writedata`  input  32  write data.
- `readdata`  output  32  read data.
- `waitrequest`  output  1  high = the current request is not accepted this cycle.
- `protocol_error`  output  1  sticky; set on a bus protocol violation.
- `range_error`  output  1  sticky; set on an access outside the mapped range.

## Operation
- **Word index and range.** index = (address − BASE_ADDR) >> 2. An access is in range iff address ≥ BASE_ADDR and index < DEPTH_WORDS.
- **Wait count W**, fixed when a request is first seen in IDLE:
  - fixed mode: READ_WAIT for reads, WRITE_WAIT for writes;
  - random mode: W = lfsr[1:0].
- **LFSR.** 16-bit Fibonacci, taps 16, 14, 13, 11. It advances by one step on every accepted transfer, in both modes.
- **State IDLE**, no request: waitrequest = 0.
- **State IDLE**, request with W = 0: accepted in the same cycle (waitrequest = 0).
- **State IDLE**, request with W > 0: waitrequest = 1, cnt ← W−1, read/write/address/byteenable/writedata are latched, next state STALL.
- **State STALL**, cnt ≠ 0: waitrequest = 1, cnt decrements.
- **State STALL**, cnt = 0: waitrequest = 0, transfer accepted, next state IDLE.
- **State STALL**, request dropped, or read/write/address changed from the latched values: protocol_error ← 1, transfer abandoned with no memory change, next state IDLE.
- **Accepted read:**
  - in range: readdata = mem[index];
  - out of range: readdata = 0 and range_error ← 1.
- **Accepted write:**
  - in range: each byte lane with byteenable = 1 is updated on the accept edge; other lanes are kept;
  - out of range: the write is dropped and range_error ← 1.
- **read and write high together:** protocol_error ← 1, accepted immediately with W = 0, no memory or readdata change.
- **Write with byteenable = 0:** legal no-op; it still consumes its wait states.

## Timing
- **Reset values** (reset low): state IDLE, cnt 0, lfsr = seed, readdata 0, protocol_error 0, range_error 0.
  - waitrequest is 0 while no request is present.
  - Memory contents are not cleared.
- **Reset mid-stall:** the transfer is aborted and no write occurs.
- **Latency:** a request is accepted in the (W+1)-th cycle it is held, so waitrequest is high for exactly W cycles.
- **waitrequest** is combinational from state, cnt, read, write and W.
- **readdata:**
  - combinationally valid in the accept cycle;
  - registered on the accept edge and held until the next accepted in-range or out-of-range read.
- **Back-to-back:** a new request in the cycle after an accept is handled from IDLE, with no dead cycle.
- **Read after write:** a read of the same word in the next transfer returns the merged data.
- **Sticky errors:** protocol_error and range_error clear only on reset.

## Test plan
- **Fixed read latency.** READ_WAIT=2, INIT word 0 = 32'h2402000A. Hold read at 32'hBFC00000 → waitrequest high for 2 cycles, low on the 3rd, with readdata = 32'h2402000A.
- **Byte-enable merge.** WRITE_WAIT=0. Write 32'hAABBCCDD then 32'h11223344 with byteenable 4'b0101 to 32'hBFC00010 → a read returns 32'hAA22CC44.
- **Out of range.** Read at 32'hBFC01000 with DEPTH_WORDS=1024 → readdata 0 and range_error 1. A following in-range write succeeds, and range_error stays 1.
- **Random stall mode.** STALL_MODE=1, seed 16'hACE1. 64 back-to-back reads:
  - each stall length equals the model LFSR's [1:0];
  - every accepted read returns the correct data.
- **Protocol violations.**
  - Drop read during a stall (READ_WAIT=3) → protocol_error 1, next request accepted normally.
  - read and write high together → protocol_error 1, memory unchanged.
- **Reset mid-write.** WRITE_WAIT=3. Assert reset low in cycle 2 of a write → word unchanged, waitrequest 0, flags 0.

Source files
------------

// File: rtl/mips_bus_stall_memory.sv
// Word-addressed Avalon-style memory slave with fixed or
// pseudo-random wait states and sticky error flags.
module mips_bus_stall_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned READ_WAIT   = 1,
  parameter int unsigned WRITE_WAIT  = 1,
  parameter int unsigned STALL_MODE  = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        protocol_error,
  output logic        range_error
);

  localparam int IW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;

  typedef enum logic {IDLE, STALL} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  w;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nx;
  logic [31:0] rdata_q;
  logic        lat_rd;
  logic        lat_wr;
  logic [31:0] lat_addr;
  logic [3:0]  lat_be;
  logic [31:0] lat_wd;
  logic        act_rd;
  logic        act_wr;
  logic [31:0] act_addr;
  logic [3:0]  act_be;
  logic [31:0] act_wd;
  logic [31:0] off;
  logic [IW-1:0] idx;
  logic        in_range;
  logic [31:0] rd_word;
  logic        req;
  logic        idle;
  logic        mismatch;
  logic        accept;
  logic        abort;
  logic        acc_rd;
  logic        acc_wr;
  logic        acc_both;
  logic        unused_bits;

  logic [31:0] mem [DEPTH_WORDS];

  assign req  = read | write;
  assign idle = (state == IDLE);

  // right-shift Fibonacci form of taps 16,14,13,11
  assign lfsr_nx = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5],
                    lfsr[15:1]};

  always_comb begin
    w = 4'd0;
    if (read && write)
      w = 4'd0;
    else if (STALL_MODE != 0)
      w = {2'b00, lfsr[1:0]};
    else if (read)
      w = 4'(READ_WAIT);
    else if (write)
      w = 4'(WRITE_WAIT);
  end

  assign mismatch = !req
                 || read != lat_rd
                 || write != lat_wr
                 || address[31:2] != lat_addr[31:2];

  assign accept = idle ? (req && w == 4'd0)
                       : (!mismatch && cnt == 4'd0);
  assign abort  = !idle && mismatch;

  assign waitrequest = idle ? (req && w != 4'd0)
                            : (req && (mismatch || cnt != 4'd0));

  // while stalled, the transfer uses what was latched at entry
  assign act_rd   = idle ? read       : lat_rd;
  assign act_wr   = idle ? write      : lat_wr;
  assign act_addr = idle ? address    : lat_addr;
  assign act_be   = idle ? byteenable : lat_be;
  assign act_wd   = idle ? writedata  : lat_wd;

  assign acc_rd   = accept && act_rd && !act_wr;
  assign acc_wr   = accept && act_wr && !act_rd;
  assign acc_both = accept && act_rd && act_wr;

  assign off      = act_addr - BASE_ADDR;
  assign idx      = off[IW+1:2];
  assign in_range = (act_addr >= BASE_ADDR)
                 && ({2'b00, off[31:2]} < DEPTH_WORDS);
  assign unused_bits = ^off[1:0];

  assign rd_word  = in_range ? mem[idx] : 32'h0;
  assign readdata = acc_rd ? rd_word : rdata_q;

  always_ff @(posedge clk) begin
    if (acc_wr && in_range) begin
      for (int b = 0; b < 4; b++)
        if (act_be[b])
          mem[idx][8*b +: 8] <= act_wd[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      lfsr           <= SEED;
      rdata_q        <= 32'h0;
      protocol_error <= 1'b0;
      range_error    <= 1'b0;
      lat_rd         <= 1'b0;
      lat_wr         <= 1'b0;
      lat_addr       <= 32'h0;
      lat_be         <= 4'h0;
      lat_wd         <= 32'h0;
    end else begin
      if (accept)
        lfsr <= lfsr_nx;
      if (acc_rd)
        rdata_q <= rd_word;
      if ((acc_rd || acc_wr) && !in_range)
        range_error <= 1'b1;
      if (acc_both || abort)
        protocol_error <= 1'b1;
      unique case (state)
        IDLE: begin
          if (req && w != 4'd0) begin
            state    <= STALL;
            cnt      <= w - 4'd1;
            lat_rd   <= read;
            lat_wr   <= write;
            lat_addr <= address;
            lat_be   <= byteenable;
            lat_wd   <= writedata;
          end
        end
        STALL: begin
          if (abort || accept)
            state <= IDLE;
          else
            cnt <= cnt - 4'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_stall_memory.sv
// Directed bench: a fixed-wait and a random-stall instance,
// both checked every cycle against a transaction-level model.
module tb_mips_bus_stall_memory;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       rd;
  logic [1:0]       wr;
  logic [1:0]       wq;
  logic [1:0]       pe;
  logic [1:0]       re;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wd;
  logic [1:0][31:0] rdat;
  logic [1:0][3:0]  be;

  int checks = 0;
  int errors = 0;

  mips_bus_stall_memory #(
    .READ_WAIT(2),
    .WRITE_WAIT(3)
  ) u_fix (
    .clk(clk), .reset(rst[0]), .address(addr[0]),
    .read(rd[0]), .write(wr[0]), .byteenable(be[0]),
    .writedata(wd[0]), .readdata(rdat[0]),
    .waitrequest(wq[0]), .protocol_error(pe[0]),
    .range_error(re[0])
  );

  mips_bus_stall_memory #(
    .STALL_MODE(1),
    .LFSR_SEED(16'hACE1)
  ) u_rnd (
    .clk(clk), .reset(rst[1]), .address(addr[1]),
    .read(rd[1]), .write(wr[1]), .byteenable(be[1]),
    .writedata(wd[1]), .readdata(rdat[1]),
    .waitrequest(wq[1]), .protocol_error(pe[1]),
    .range_error(re[1])
  );

  // model: a request is held for W cycles, then taken
  bit          m_busy [2];
  int          m_held [2];
  int          m_w [2];
  logic        m_lrd [2];
  logic        m_lwr [2];
  logic [31:0] m_laddr [2];
  logic [3:0]  m_lbe [2];
  logic [31:0] m_lwd [2];
  logic [15:0] m_lfsr [2];
  logic        m_perr [2];
  logic        m_rerr [2];
  logic [31:0] m_rdata [2];
  logic [31:0] mmem [int];

  logic        e_wait;
  logic        e_acc;
  logic        e_abort;
  logic        e_rd;
  logic        e_wr;
  logic [31:0] e_addr;
  logic [3:0]  e_be;
  logic [31:0] e_wd;

  task automatic chk(string nm, int k,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got %h, want %h",
               nm, k, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] lstep(logic [15:0] l);
    return {l[16-16] ^ l[16-14] ^ l[16-13] ^ l[16-11],
            l[15:1]};
  endfunction

  function automatic bit inr(logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < 1024);
  endfunction

  function automatic int key(int k, logic [31:0] a);
    return k * 4096 + int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] rd_expect(int k,
                                            logic [31:0] a);
    if (!inr(a))
      return 32'h0;
    if (mmem.exists(key(k, a)))
      return mmem[key(k, a)];
    return 'x;
  endfunction

  function automatic int want_w(int k);
    if (rd[k] && wr[k])
      return 0;
    if (k == 1)
      return int'(m_lfsr[1][1:0]);
    return rd[k] ? 2 : 3;
  endfunction

  function automatic logic [31:0] pat(int i);
    return 32'h5A5A0000 ^ (32'(i) * 32'h01010101);
  endfunction

  task automatic model_reset(int k);
    m_busy[k]  = 0;
    m_held[k]  = 0;
    m_lfsr[k]  = 16'hACE1;
    m_perr[k]  = 1'b0;
    m_rerr[k]  = 1'b0;
    m_rdata[k] = 32'h0;
  endtask

  task automatic eval(int k);
    e_wait  = 1'b0;
    e_acc   = 1'b0;
    e_abort = 1'b0;
    if (!m_busy[k]) begin
      e_rd = rd[k];  e_wr = wr[k];  e_addr = addr[k];
      e_be = be[k];  e_wd = wd[k];
      if (rd[k] || wr[k]) begin
        if (want_w(k) == 0) e_acc = 1'b1;
        else e_wait = 1'b1;
      end
    end else begin
      e_rd = m_lrd[k];  e_wr = m_lwr[k];
      e_addr = m_laddr[k];
      e_be = m_lbe[k];  e_wd = m_lwd[k];
      if (rd[k] != m_lrd[k] || wr[k] != m_lwr[k]
          || addr[k][31:2] != m_laddr[k][31:2]) begin
        e_abort = 1'b1;
        e_wait  = rd[k] | wr[k];
      end else if (m_held[k] == m_w[k])
        e_acc = 1'b1;
      else
        e_wait = 1'b1;
    end
  endtask

  task automatic mwrite(int k);
    logic [31:0] v;
    v = mmem.exists(key(k, e_addr)) ? mmem[key(k, e_addr)]
                                    : 'x;
    for (int b = 0; b < 4; b++)
      if (e_be[b]) v[8*b +: 8] = e_wd[8*b +: 8];
    mmem[key(k, e_addr)] = v;
  endtask

  // compare on the falling edge, then advance the model
  // to the state it must have after the next rising edge
  initial begin
    logic [31:0] er;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        eval(k);
        chk("waitrequest", k, 32'(wq[k]), 32'(e_wait));
        chk("protocol_error", k, 32'(pe[k]), 32'(m_perr[k]));
        chk("range_error", k, 32'(re[k]), 32'(m_rerr[k]));
        er = m_rdata[k];
        if (e_acc && e_rd && !e_wr)
          er = rd_expect(k, e_addr);
        if (!$isunknown(er))
          chk("readdata", k, rdat[k], er);
        if (rst[k]) begin
          if (e_abort) begin
            m_perr[k] = 1'b1;
            m_busy[k] = 0;
          end else if (e_acc) begin
            m_lfsr[k] = lstep(m_lfsr[k]);
            m_busy[k] = 0;
            if (e_rd && e_wr)
              m_perr[k] = 1'b1;
            else if (!inr(e_addr)) begin
              m_rerr[k] = 1'b1;
              if (e_rd) m_rdata[k] = 32'h0;
            end else if (e_rd)
              m_rdata[k] = rd_expect(k, e_addr);
            else
              mwrite(k);
          end else if (m_busy[k])
            m_held[k]++;
          else if (rd[k] || wr[k]) begin
            m_w[k]     = want_w(k);
            m_busy[k]  = 1;
            m_held[k]  = 1;
            m_lrd[k]   = rd[k];
            m_lwr[k]   = wr[k];
            m_laddr[k] = addr[k];
            m_lbe[k]   = be[k];
            m_lwd[k]   = wd[k];
          end
        end
      end
    end
  end

  task automatic xfer(int k, logic r, logic w,
                      logic [31:0] a, logic [3:0] b,
                      logic [31:0] d,
                      output int st, output logic [31:0] q);
    bit done = 0;
    rd[k] = r;  wr[k] = w;  addr[k] = a;
    be[k] = b;  wd[k] = d;
    st = 0;
    q = 'x;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!wq[k]) begin
        done = 1;
        q = rdat[k];
      end else
        st++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout[%0d]: waitrequest=%b, want 0",
               k, wq[k]);
    end
    @(posedge clk);
    #1;
    rd[k] = 1'b0;
    wr[k] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run=timeout, want done");
    $fatal(1);
  end

  initial begin
    int st;
    int ew;
    logic [31:0] q;
    rst = '0;  rd = '0;  wr = '0;
    addr = '0; be = '0;  wd = '0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge clk);
    #1;
    rst = 2'b11;
    chk("rst_readdata", 0, rdat[0], 32'h0);
    chk("rst_wait", 0, 32'(wq[0]), 32'h0);
    chk("rst_perr", 0, 32'(pe[0]), 32'h0);
    chk("rst_rerr", 0, 32'(re[0]), 32'h0);

    xfer(0, 0, 1, BASE, 4'hF, 32'h2402000A, st, q);
    chk("w_stall", 0, st, 3);
    xfer(0, 1, 0, BASE, 4'hF, 32'h0, st, q);
    chk("r_stall", 0, st, 2);
    chk("r_data", 0, q, 32'h2402000A);

    xfer(0, 0, 1, BASE + 16, 4'hF, 32'hAABBCCDD, st, q);
    xfer(0, 0, 1, BASE + 16, 4'b0101, 32'h11223344, st, q);
    xfer(0, 1, 0, BASE + 16, 4'hF, 32'h0, st, q);
    chk("merge", 0, q, 32'hAA22CC44);

    xfer(0, 1, 0, BASE + 32'h1000, 4'hF, 32'h0, st, q);
    chk("oor_data", 0, q, 32'h0);
    chk("oor_flag", 0, 32'(re[0]), 32'h1);
    xfer(0, 0, 1, BASE + 4, 4'hF, 32'h12345678, st, q);
    xfer(0, 1, 0, BASE + 4, 4'hF, 32'h0, st, q);
    chk("post_oor", 0, q, 32'h12345678);
    chk("oor_sticky", 0, 32'(re[0]), 32'h1);

    rd[0] = 1'b1;
    addr[0] = BASE;
    @(posedge clk);
    #1;
    rd[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_perr", 0, 32'(pe[0]), 32'h1);
    xfer(0, 1, 0, BASE + 16, 4'hF, 32'h0, st, q);
    chk("after_drop_stall", 0, st, 2);
    chk("after_drop_data", 0, q, 32'hAA22CC44);

    xfer(0, 1, 1, BASE, 4'hF, 32'hFFFFFFFF, st, q);
    chk("both_stall", 0, st, 0);
    chk("both_data", 0, q, 32'hAA22CC44);
    xfer(0, 1, 0, BASE, 4'hF, 32'h0, st, q);
    chk("both_mem", 0, q, 32'h2402000A);

    xfer(0, 0, 1, BASE, 4'h0, 32'h0, st, q);
    chk("be0_stall", 0, st, 3);
    xfer(0, 1, 0, BASE, 4'hF, 32'h0, st, q);
    chk("be0_mem", 0, q, 32'h2402000A);

    wr[0] = 1'b1;  addr[0] = BASE;
    be[0] = 4'hF;  wd[0] = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    wr[0] = 1'b0;
    model_reset(0);
    #1;
    chk("rstw_wait", 0, 32'(wq[0]), 32'h0);
    chk("rstw_perr", 0, 32'(pe[0]), 32'h0);
    chk("rstw_rerr", 0, 32'(re[0]), 32'h0);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    xfer(0, 1, 0, BASE, 4'hF, 32'h0, st, q);
    chk("rstw_mem", 0, q, 32'h2402000A);

    for (int i = 0; i < 8; i++) begin
      ew = int'(m_lfsr[1][1:0]);
      xfer(1, 0, 1, BASE + 32'(4 * i), 4'hF, pat(i), st, q);
      chk("rnd_wstall", 1, st, ew);
      if (i == 0) chk("rnd_first", 1, st, 1);
      if (i == 1) chk("rnd_second", 1, st, 0);
    end
    for (int j = 0; j < 64; j++) begin
      ew = int'(m_lfsr[1][1:0]);
      xfer(1, 1, 0, BASE + 32'(4 * (j % 8)), 4'hF, 32'h0,
           st, q);
      chk("rnd_rstall", 1, st, ew);
      chk("rnd_data", 1, q, pat(j % 8));
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
